// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Time-multiplexed multi-digit 7-segment driver. A packed nibble word is
//   latched into shadow registers on load. The digits are then scanned one
//   per slot, and each slot starts with an all-commons-off gap to avoid ghosting.
//
// Ports
//   clk         system clock
//   rst         asynchronous reset, active-high
//   din         packed nibbles, digit i = din[4i+3:4i], digit 0 rightmost
//   dp_in       decimal point request per digit
//   lz_blank    1 = suppress leading zeros (sampled live)
//   load        capture din/dp_in into the shadow registers
//   seg         segments {g,f,e,d,c,b,a}, active-high, registered
//   dp          decimal point, active-high, registered
//   com         one-hot digit enable, active-high, registered
//   frame_done  one-cycle pulse as the last digit's slot ends
module seg_scan_driver #(
   parameter int DIGITS    = 4,
   parameter int PRESCALE  = 2500,
   parameter int BLANK_CYC = 2,
   parameter int HEX_MODE  = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   din,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic                  lz_blank,
   input  logic                  load,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [DIGITS-1:0]     com,
   output logic                  frame_done
);

   localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CMAX = (PRESCALE > BLANK_CYC) ? PRESCALE : BLANK_CYC;
   localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

   typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [4*DIGITS-1:0] data_q, data_d;
   logic [DIGITS-1:0]   dpsh_q, dpsh_d;
   logic                fd_pre_q, fd_pre_d;
   logic [6:0]          seg_q, seg_d;
   logic                dp_q, dp_d;
   logic [DIGITS-1:0]   com_q, com_d;
   logic                fd_q, fd_d;

   logic [DIGITS-1:0]   sup;      // digit i is a leading zero
   logic [3:0]          cur_nib;
   logic                cur_dp;
   logic                cur_sup;
   logic                last_dig;

   function automatic logic [6:0] glyph(input logic [3:0] n);
      logic [6:0] g;
      case (n)
         4'h0: g = 7'b0111111;
         4'h1: g = 7'b0000110;
         4'h2: g = 7'b1011011;
         4'h3: g = 7'b1001111;
         4'h4: g = 7'b1100110;
         4'h5: g = 7'b1101101;
         4'h6: g = 7'b1111101;
         4'h7: g = 7'b0000111;
         4'h8: g = 7'b1111111;
         4'h9: g = 7'b1101111;
         4'hA: g = 7'b1110111;
         4'hB: g = 7'b1111100;
         4'hC: g = 7'b0111001;
         4'hD: g = 7'b1011110;
         4'hE: g = 7'b1111001;
         default: g = 7'b1110001;
      endcase
      if (HEX_MODE == 0 && n > 4'h9) g = 7'b0000000;
      return g;
   endfunction

   // Walk from the most significant digit down; a digit is a leading zero
   // while every digit at or above it is zero. Digit 0 always shows.
   always_comb begin
      logic allz;
      allz = 1'b1;
      sup  = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         allz   = allz & (data_q[4*i +: 4] == 4'h0);
         sup[i] = allz && (i != 0);
      end
   end

   always_comb begin
      cur_nib = 4'h0;
      cur_dp  = 1'b0;
      cur_sup = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IW'(i)) begin
            cur_nib = data_q[4*i +: 4];
            cur_dp  = dpsh_q[i];
            cur_sup = sup[i];
         end
      end
   end

   assign last_dig = (idx_q == IW'(DIGITS - 1));

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + CW'(1);
      idx_d    = idx_q;
      fd_pre_d = 1'b0;
      data_d   = load ? din   : data_q;
      dpsh_d   = load ? dp_in : dpsh_q;
      case (state_q)
         BLANK: begin
            if (cnt_q == CW'(BLANK_CYC - 1)) begin
               state_d = SHOW;
               cnt_d   = '0;
            end
         end
         default: begin
            if (cnt_q == CW'(PRESCALE - 1)) begin
               state_d  = BLANK;
               cnt_d    = '0;
               idx_d    = last_dig ? '0 : idx_q + IW'(1);
               fd_pre_d = last_dig;
            end
         end
      endcase

      // Outputs are a registered image of the current state, one cycle late.
      seg_d = 7'b0;
      dp_d  = 1'b0;
      com_d = '0;
      if (state_q == SHOW) begin
         for (int i = 0; i < DIGITS; i++) com_d[i] = (idx_q == IW'(i));
         seg_d = (lz_blank && cur_sup) ? 7'b0 : glyph(cur_nib);
         dp_d  = cur_dp;
      end
      // fd_pre marks the last SHOW cycle; delaying it once more lines the
      // pulse up with com dropping to zero.
      fd_d = fd_pre_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= BLANK;
         cnt_q    <= '0;
         idx_q    <= '0;
         data_q   <= '0;
         dpsh_q   <= '0;
         fd_pre_q <= 1'b0;
         seg_q    <= '0;
         dp_q     <= 1'b0;
         com_q    <= '0;
         fd_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         data_q   <= data_d;
         dpsh_q   <= dpsh_d;
         fd_pre_q <= fd_pre_d;
         seg_q    <= seg_d;
         dp_q     <= dp_d;
         com_q    <= com_d;
         fd_q     <= fd_d;
      end
   end

   assign seg        = seg_q;
   assign dp         = dp_q;
   assign com        = com_q;
   assign frame_done = fd_q;

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Multi-digit, time-multiplexed 7-segment display driver; successor to the single-digit combinational BCD decoder.
- Latches a packed nibble word and scans DIGITS common lines, one digit per slot, with an anti-ghosting blank gap between slots.
- Options: BCD or hex glyphs, decimal points, leading-zero suppression.
- Sits between the clock/counter logic and the board display pins.

Parameters:
DIGITS, 4, number of digits scanned (legal 1..8)
PRESCALE, 2500, clk cycles a digit is lit per slot (>=1)
BLANK_CYC, 2, clk cycles all commons off before each slot (>=1)
HEX_MODE, 0, 0: nibbles 0xA-0xF render blank; 1: render A b C d E F

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
din  in  4*DIGITS  packed nibbles; digit i = din[4i+3:4i]; digit 0 is least significant / rightmost
dp_in  in  DIGITS  decimal point request per digit
lz_blank  in  1  1 = suppress leading zeros
load  in  1  on a rising clk edge with load=1, capture din/dp_in into the shadow registers
seg  out  7  segments {g,f,e,d,c,b,a}, active-high, registered
dp  out  1  decimal point, active-high, registered
com  out  DIGITS  one-hot digit enable, active-high, registered
frame_done  out  1  one-cycle pulse at the end of the last digit's slot

Behaviour:
- Reset (async, rst=1): shadow data and dp registers = 0; state = BLANK; digit index = 0; counter = 0; seg = 0; dp = 0; com = 0; frame_done = 0.
- FSM states BLANK and SHOW. The counter increments every clk.
- BLANK: when the counter reaches BLANK_CYC-1, go to SHOW and clear the counter.
- SHOW: when the counter reaches PRESCALE-1, go to BLANK, clear the counter, and advance the index (DIGITS-1 wraps to 0).
- Slot length is BLANK_CYC+PRESCALE cycles. Frame length is DIGITS*(BLANK_CYC+PRESCALE) cycles.
- Scan order is 0, 1, …, DIGITS-1, 0, …
- Outputs are registered from the current state/index, so they lag the state by one cycle.
  - While in BLANK: com = 0, seg = 0, dp = 0.
  - While in SHOW: com = 1<<idx; seg = glyph(shadow digit idx); dp = shadow_dp[idx].
- Exactly zero or one com bit is ever high. Transitions go through an all-off cycle, never directly from one digit to another.
- Glyphs:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - HEX_MODE=1: A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001
  - HEX_MODE=0: 0xA-0xF give 0000000.
- Leading-zero suppression: with lz_blank=1, digit i (i>0) shows seg=0 when shadow digits DIGITS-1 down to i are all zero. Digit 0 is never suppressed. dp is unaffected by suppression. lz_blank is sampled live, not latched.
- Load:
  - The shadow updates at the edge where load=1.
  - seg reflects the new value from the following edge if the SHOW slot of that digit is in progress. No restart of the scan.
  - load held high: shadow tracks din every cycle.
- frame_done: high for one cycle, coincident with com going to 0 after digit DIGITS-1's SHOW.
- DIGITS=1: com is 1 during SHOW; frame_done fires every slot.
- Reset mid-slot: all outputs go to 0 immediately (asynchronous). Scanning restarts at digit 0 with BLANK after rst falls.

Test Plan:
- DIGITS=4, PRESCALE=4, BLANK_CYC=1, rst released, load din=0x1234 -> com sequence 0000, 0001×4, 0000, 0010×4, 0000, 0100×4, 0000, 1000×4, repeating; seg for digit 0 = 1100110 ('4'); frame_done pulses every 20 cycles.
- Sweep nibble 0..F in HEX_MODE=0 and 1 -> seg matches the glyph list; 0xA with HEX_MODE=0 -> 0000000; 0xA with HEX_MODE=1 -> 1110111.
- lz_blank=1, din=0x0050 -> digits 3 and 2 show seg=0; digit 1 shows 1101101; digit 0 shows 0111111. din=0x0000 -> only digit 0 shows '0'. lz_blank=0 -> all four show '0'.
- dp_in=4'b0100 with lz_blank=1, din=0x0000 -> dp=1 only while com=0100, with seg=0.
- load din 0x1111→0x2222 mid-slot of digit 0 -> seg changes from 0000110 to 1011011 one cycle after the load edge; com timing unchanged.
- Assert rst during the SHOW of digit 2 -> seg/com/dp/frame_done = 0 immediately. After release, the first lit digit is digit 0 after BLANK_CYC cycles, showing shadow value 0 (0111111).
